uart_serial_fifo: RTL and testbench

- Byte-oriented full-duplex UART core: 8N1 serial transmitter and receiver, each buffered by a synchronous FIFO.
- Sits between a bus-facing register wrapper and the rx/tx pins.
- The wrapper pushes TX bytes, pops RX bytes and reads full/empty status; the core handles serialisation, deserialisation and buffer drain/fill autonomously.

---
 rtl/uart_serial_fifo.sv | 261 ++++++++++++++++++++++++++
 tb/tb_uart_serial_fifo.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_serial_fifo.sv
// 8N1 UART core: TX and RX engines, each buffered by a synchronous FIFO.
// Define UART_LOOPBACK_EN to add the loopback port (internal tx feeds the receiver).

module uart_serial_fifo_buf #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic             full
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr;
  logic             push_ok, pop_ok;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= push_data;
  end
endmodule

module uart_serial_fifo #(
  parameter int CLK_FREQ     = 25000000,
  parameter int BIT_RATE     = 9600,
  parameter int PAYLOAD_BITS = 8,
  parameter int BUFFER_SIZE  = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    rx,
  output logic                    tx,
`ifdef UART_LOOPBACK_EN
  input  logic                    loopback,
`endif
  input  logic                    tx_push,
  input  logic [PAYLOAD_BITS-1:0] tx_data,
  output logic                    tx_full,
  output logic                    tx_empty,
  input  logic                    rx_pop,
  output logic [PAYLOAD_BITS-1:0] rx_data,
  output logic                    rx_empty,
  output logic                    rx_full,
  output logic                    rx_overflow,
  output logic                    rx_break
);
  localparam int CPB_RAW        = CLK_FREQ / BIT_RATE;
  localparam int CYCLES_PER_BIT = (CPB_RAW < 4) ? 4 : CPB_RAW;
  localparam int CNT_W          = $clog2(CYCLES_PER_BIT);
  localparam int BIT_W          = (PAYLOAD_BITS > 1) ? $clog2(PAYLOAD_BITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CYCLES_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CYCLES_PER_BIT / 2 - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(PAYLOAD_BITS - 1);

  // ---------------- transmitter ----------------
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

  tx_state_t               tx_state, tx_state_nxt;
  logic [CNT_W-1:0]        tx_cnt, tx_cnt_nxt;
  logic [BIT_W-1:0]        tx_bit, tx_bit_nxt;
  logic [PAYLOAD_BITS-1:0] tx_shift, tx_shift_nxt;
  logic [PAYLOAD_BITS-1:0] tx_head;
  logic                    tx_fifo_pop;
  logic                    tx_line;

  uart_serial_fifo_buf #(.WIDTH(PAYLOAD_BITS), .DEPTH(BUFFER_SIZE)) u_tx_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (tx_push),
    .push_data (tx_data),
    .pop       (tx_fifo_pop),
    .head      (tx_head),
    .empty     (tx_empty),
    .full      (tx_full)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
    end else begin
      tx_state <= tx_state_nxt;
      tx_cnt   <= tx_cnt_nxt;
      tx_bit   <= tx_bit_nxt;
      tx_shift <= tx_shift_nxt;
    end
  end

  always_comb begin
    tx_state_nxt = tx_state;
    tx_cnt_nxt   = tx_cnt;
    tx_bit_nxt   = tx_bit;
    tx_shift_nxt = tx_shift;
    tx_fifo_pop  = 1'b0;
    tx_line      = 1'b1;
    case (tx_state)
      TX_IDLE: begin
        if (!tx_empty) begin
          tx_fifo_pop  = 1'b1;
          tx_shift_nxt = tx_head;
          tx_cnt_nxt   = CNT_LAST;
          tx_state_nxt = TX_START;
        end
      end
      TX_START: begin
        tx_line = 1'b0;
        if (tx_cnt == '0) begin
          tx_cnt_nxt   = CNT_LAST;
          tx_bit_nxt   = '0;
          tx_state_nxt = TX_DATA;
        end else begin
          tx_cnt_nxt = tx_cnt - 1'b1;
        end
      end
      TX_DATA: begin
        tx_line = tx_shift[0];
        if (tx_cnt == '0) begin
          tx_cnt_nxt   = CNT_LAST;
          tx_shift_nxt = tx_shift >> 1;
          if (tx_bit == BIT_LAST) tx_state_nxt = TX_STOP;
          else                    tx_bit_nxt   = tx_bit + 1'b1;
        end else begin
          tx_cnt_nxt = tx_cnt - 1'b1;
        end
      end
      TX_STOP: begin
        if (tx_cnt == '0) tx_state_nxt = TX_IDLE;
        else              tx_cnt_nxt   = tx_cnt - 1'b1;
      end
      default: tx_state_nxt = TX_IDLE;
    endcase
  end

  // ---------------- line routing ----------------
  logic rx_src;
`ifdef UART_LOOPBACK_EN
  assign rx_src = loopback ? tx_line : rx;
  assign tx     = loopback ? 1'b1 : tx_line;
`else
  assign rx_src = rx;
  assign tx     = tx_line;
`endif

  // ---------------- receiver ----------------
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT} rx_state_t;

  rx_state_t               rx_state, rx_state_nxt;
  logic [CNT_W-1:0]        rx_cnt, rx_cnt_nxt;
  logic [BIT_W-1:0]        rx_bit, rx_bit_nxt;
  logic [PAYLOAD_BITS-1:0] rx_shift, rx_shift_nxt;
  logic                    rx_meta, rx_sync;
  logic                    rx_fifo_push;

  uart_serial_fifo_buf #(.WIDTH(PAYLOAD_BITS), .DEPTH(BUFFER_SIZE)) u_rx_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (rx_fifo_push),
    .push_data (rx_shift),
    .pop       (rx_pop),
    .head      (rx_data),
    .empty     (rx_empty),
    .full      (rx_full)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta  <= 1'b1;
      rx_sync  <= 1'b1;
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
    end else begin
      rx_meta  <= rx_src;
      rx_sync  <= rx_meta;
      rx_state <= rx_state_nxt;
      rx_cnt   <= rx_cnt_nxt;
      rx_bit   <= rx_bit_nxt;
      rx_shift <= rx_shift_nxt;
    end
  end

  always_comb begin
    rx_state_nxt = rx_state;
    rx_cnt_nxt   = rx_cnt;
    rx_bit_nxt   = rx_bit;
    rx_shift_nxt = rx_shift;
    rx_fifo_push = 1'b0;
    rx_break     = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        if (!rx_sync) begin
          rx_cnt_nxt   = CNT_HALF;
          rx_state_nxt = RX_START;
        end
      end
      RX_START: begin
        if (rx_cnt == '0) begin
          if (rx_sync) begin
            rx_state_nxt = RX_IDLE;
          end else begin
            rx_cnt_nxt   = CNT_LAST;
            rx_bit_nxt   = '0;
            rx_state_nxt = RX_DATA;
          end
        end else begin
          rx_cnt_nxt = rx_cnt - 1'b1;
        end
      end
      RX_DATA: begin
        if (rx_cnt == '0) begin
          rx_cnt_nxt   = CNT_LAST;
          rx_shift_nxt = PAYLOAD_BITS'({rx_sync, rx_shift} >> 1);
          if (rx_bit == BIT_LAST) rx_state_nxt = RX_STOP;
          else                    rx_bit_nxt   = rx_bit + 1'b1;
        end else begin
          rx_cnt_nxt = rx_cnt - 1'b1;
        end
      end
      RX_STOP: begin
        if (rx_cnt == '0) begin
          rx_state_nxt = RX_WAIT;
          // a bad stop bit is a break only when the data bits were all low too
          if (rx_sync)              rx_fifo_push = 1'b1;
          else if (rx_shift == '0)  rx_break     = 1'b1;
        end else begin
          rx_cnt_nxt = rx_cnt - 1'b1;
        end
      end
      RX_WAIT: begin
        if (rx_sync) rx_state_nxt = RX_IDLE;
      end
      default: rx_state_nxt = RX_IDLE;
    endcase
  end

  assign rx_overflow = rx_fifo_push && rx_full;
endmodule

// File: tb/tb_uart_serial_fifo.sv
// Self-checking bench for uart_serial_fifo at 10 cycles per bit.
// Build with UART_LOOPBACK_EN defined to also exercise the loopback path.

module tb_uart_serial_fifo;
  localparam int CPB = 10;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx = 1'b1;
  logic       tx;
  logic       tx_push = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_full, tx_empty;
  logic       rx_pop = 1'b0;
  logic [7:0] rx_data;
  logic       rx_empty, rx_full, rx_overflow, rx_break;
`ifdef UART_LOOPBACK_EN
  logic       loopback = 1'b0;
`endif

  int errors = 0;
  int checks = 0;
  int break_cnt = 0;
  int ovf_cnt = 0;
  logic [7:0] tx_q[$];
  logic [7:0] rx_q[$];

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       exp_byte;
  } rx_vec_t;
  rx_vec_t rx_vec[7];

  uart_serial_fifo #(
    .CLK_FREQ(1000000), .BIT_RATE(100000), .PAYLOAD_BITS(8), .BUFFER_SIZE(8)
  ) dut (
    .clk(clk), .reset(reset), .rx(rx), .tx(tx),
`ifdef UART_LOOPBACK_EN
    .loopback(loopback),
`endif
    .tx_push(tx_push), .tx_data(tx_data), .tx_full(tx_full), .tx_empty(tx_empty),
    .rx_pop(rx_pop), .rx_data(rx_data), .rx_empty(rx_empty), .rx_full(rx_full),
    .rx_overflow(rx_overflow), .rx_break(rx_break)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!reset) begin
      if (rx_break)    break_cnt++;
      if (rx_overflow) ovf_cnt++;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic push_tx(input logic [7:0] d);
    tx_data = d;
    tx_push = 1'b1;
    tx_q.push_back(d);
    @(negedge clk);
    tx_push = 1'b0;
  endtask

  // Captures one frame starting at the first low sample; every bit must hold exactly CPB cycles.
  task automatic tx_capture(output logic [7:0] b, output logic ok);
    logic [9:0] bits;
    int w;
    ok = 1'b1;
    b = 8'h00;
    w = 0;
    bits = '0;
    while (tx !== 1'b0 && w < 400) begin
      @(negedge clk);
      w++;
    end
    if (tx !== 1'b0) begin
      ok = 1'b0;
      return;
    end
    for (int p = 0; p < 10; p++) begin
      if (p > 0) @(negedge clk);
      bits[p] = tx;
      for (int s = 1; s < CPB; s++) begin
        @(negedge clk);
        if (tx !== bits[p]) ok = 1'b0;
      end
    end
    if (bits[0] !== 1'b0 || bits[9] !== 1'b1) ok = 1'b0;
    b = bits[8:1];
  endtask

  task automatic check_tx_frame(input string name);
    logic [7:0] b;
    logic       ok;
    tx_capture(b, ok);
    chk({name, "_frame"}, ok, 1);
    if (tx_q.size() == 0) chk({name, "_queue"}, 0, 1);
    else                  chk({name, "_byte"}, b, tx_q.pop_front());
  endtask

  task automatic rx_frame(input logic [7:0] d, input logic stop);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic drain_rx(input string name);
    int n;
    n = 0;
    while (!rx_empty && n < 16) begin
      if (rx_q.size() == 0) chk({name, "_unexpected"}, rx_data, 0);
      else                  chk({name, "_data"}, rx_data, rx_q.pop_front());
      rx_pop = 1'b1;
      @(negedge clk);
      rx_pop = 1'b0;
      n++;
    end
    chk({name, "_missing"}, rx_q.size(), 0);
    chk({name, "_empty"}, rx_empty, 1);
  endtask

  initial begin
    int brk0, ovf0;

    rx_vec[0] = '{8'h3C, 1'b1, 1'b1};
    rx_vec[1] = '{8'h00, 1'b1, 1'b1};
    rx_vec[2] = '{8'hFF, 1'b1, 1'b1};
    rx_vec[3] = '{8'h55, 1'b0, 1'b0};
    rx_vec[4] = '{8'h80, 1'b1, 1'b1};
    rx_vec[5] = '{8'h01, 1'b1, 1'b1};
    rx_vec[6] = '{8'hC3, 1'b1, 1'b1};

    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_tx", tx, 1);
    chk("rst_tx_empty", tx_empty, 1);
    chk("rst_tx_full", tx_full, 0);
    chk("rst_rx_empty", rx_empty, 1);
    chk("rst_rx_full", rx_full, 0);
    chk("rst_rx_overflow", rx_overflow, 0);
    chk("rst_rx_break", rx_break, 0);

    // single byte, cycle-exact start
    push_tx(8'hA5);
    chk("a5_tx_empty_after_push", tx_empty, 0);
    chk("a5_tx_idle_after_push", tx, 1);
    @(negedge clk);
    chk("a5_tx_empty_after_pop", tx_empty, 1);
    chk("a5_start_low", tx, 0);
    check_tx_frame("a5");
    repeat (3) @(negedge clk);
    chk("a5_idle_high", tx, 1);

    // nine back-to-back pushes while idle
    fork
      begin
        for (int i = 1; i <= 9; i++) begin
          if (i == 9) chk("tx_full_before_9th", tx_full, 0);
          push_tx(8'(i));
        end
        chk("tx_full_after_9th", tx_full, 1);
      end
      begin
        for (int i = 0; i < 9; i++) check_tx_frame("burst");
      end
    join
    repeat (5) @(negedge clk);
    chk("burst_tx_empty", tx_empty, 1);

    // receive 0x3C after a short glitch
    brk0 = break_cnt;
    rx = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    repeat (30) @(negedge clk);
    chk("glitch_rx_empty", rx_empty, 1);
    rx_frame(8'h3C, 1'b1);
    chk("rx3c_not_empty", rx_empty, 0);
    chk("rx3c_data", rx_data, 8'h3C);
    rx_pop = 1'b1;
    @(negedge clk);
    rx_pop = 1'b0;
    chk("rx3c_empty_after_pop", rx_empty, 1);
    repeat (CPB) @(negedge clk);

    // table of received frames
    foreach (rx_vec[i]) begin
      rx_frame(rx_vec[i].data, rx_vec[i].stop);
      if (rx_vec[i].exp_byte) rx_q.push_back(rx_vec[i].data);
      chk("vec_rx_empty", rx_empty, 32'(!rx_vec[i].exp_byte));
      repeat (CPB) @(negedge clk);
      drain_rx("vec");
    end
    chk("no_break_from_framing", break_cnt - brk0, 0);

    // fill and overflow
    ovf0 = ovf_cnt;
    for (int i = 0; i < 9; i++) begin
      if (i == 7) chk("rx_full_before_8th", rx_full, 0);
      rx_frame(8'h10 + 8'(i), 1'b1);
      if (i < 8) rx_q.push_back(8'h10 + 8'(i));
      if (i == 7) chk("rx_full_after_8th", rx_full, 1);
      repeat (2) @(negedge clk);
    end
    chk("rx_overflow_once", ovf_cnt - ovf0, 1);
    drain_rx("ovf");

    // break
    brk0 = break_cnt;
    rx = 1'b0;
    repeat (12 * CPB) @(negedge clk);
    rx = 1'b1;
    repeat (20) @(negedge clk);
    chk("break_once", break_cnt - brk0, 1);
    chk("break_rx_empty", rx_empty, 1);

    // reset mid-frame
    push_tx(8'h00);
    push_tx(8'h11);
    repeat (35) @(negedge clk);
    chk("midframe_tx_low", tx, 0);
    chk("midframe_tx_not_empty", tx_empty, 0);
    reset = 1'b1;
    @(negedge clk);
    chk("reset_tx_high", tx, 1);
    chk("reset_tx_empty", tx_empty, 1);
    reset = 1'b0;
    tx_q.delete();
    repeat (20) @(negedge clk);
    chk("reset_no_resume", tx, 1);

`ifdef UART_LOOPBACK_EN
    begin
      int w;
      logic tx_dipped;
      loopback = 1'b1;
      tx_dipped = 1'b0;
      push_tx(8'h5A);
      tx_q.delete();
      w = 0;
      while (rx_empty && w < 300) begin
        @(negedge clk);
        if (tx !== 1'b1) tx_dipped = 1'b1;
        w++;
      end
      chk("loop_rx_arrived", rx_empty, 0);
      chk("loop_rx_data", rx_data, 8'h5A);
      chk("loop_tx_pin_high", tx_dipped, 0);
      rx_pop = 1'b1;
      @(negedge clk);
      rx_pop = 1'b0;
      loopback = 1'b0;
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
